// File: rtl/layer_color_mapper_if.sv
// Pixel-side bundle for layer_color_mapper: layer flags,
// frame/hit events, palette write port and RGB outputs.
interface layer_color_mapper_if #(
  parameter int LANES = 4
);
  localparam int AW = $clog2(2 * LANES + 3);

  logic             frame_tick;
  logic             pixel_valid;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic             is_ball;
  logic [LANES-1:0] display_arrow;
  logic [LANES-1:0] is_receptor;
  logic             is_receptor_background;
  logic             is_background;
  logic [LANES-1:0] hit_pulse;
  logic             pal_we;
  logic [AW-1:0]    pal_addr;
  logic [23:0]      pal_data;
  logic [7:0]       VGA_R;
  logic [7:0]       VGA_G;
  logic [7:0]       VGA_B;
  logic             out_valid;

  modport master (
    output frame_tick,
    output pixel_valid,
    output DrawX,
    output DrawY,
    output is_ball,
    output display_arrow,
    output is_receptor,
    output is_receptor_background,
    output is_background,
    output hit_pulse,
    output pal_we,
    output pal_addr,
    output pal_data,
    input  VGA_R,
    input  VGA_G,
    input  VGA_B,
    input  out_valid
  );

  modport slave (
    input  frame_tick,
    input  pixel_valid,
    input  DrawX,
    input  DrawY,
    input  is_ball,
    input  display_arrow,
    input  is_receptor,
    input  is_receptor_background,
    input  is_background,
    input  hit_pulse,
    input  pal_we,
    input  pal_addr,
    input  pal_data,
    output VGA_R,
    output VGA_G,
    output VGA_B,
    output out_valid
  );
endinterface

// File: rtl/layer_color_mapper.sv
// Two-stage layer-to-RGB mapper: priority select, then palette
// lookup with receptor hit flash and gradient fallback.
module layer_color_mapper #(
  parameter int LANES        = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_STEP   = 16,
  parameter int GRAD_EN      = 1
) (
  input logic Clk,
  input logic Reset,
  layer_color_mapper_if.slave bus
);
  localparam int N  = 2 * LANES + 3;
  localparam int AW = $clog2(N);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [AW-1:0] IDX_BALL = '0;
  localparam logic [AW-1:0] IDX_ARW  = AW'(1);
  localparam logic [AW-1:0] IDX_RCP  = AW'(1 + LANES);
  localparam logic [AW-1:0] IDX_RBG  = AW'(2 * LANES + 1);
  localparam logic [AW-1:0] IDX_BG   = AW'(2 * LANES + 2);
  localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

  typedef enum logic [2:0] {
    SRC_BALL,
    SRC_ARROW,
    SRC_RCPT,
    SRC_RBG,
    SRC_BG,
    SRC_GRAD
  } src_e;

  typedef struct packed {
    logic          valid;
    src_e          src;
    logic [AW-1:0] idx;
    logic [LW-1:0] lane;
    logic [3:0]    flash;
    logic [6:0]    xq;
  } s1_t;

  function automatic logic [23:0] pal_init(int i);
    logic [23:0] v;
    v = 24'h000000;
    if (i == 0) begin
      v = 24'hFFFFFF;
    end else if (i <= LANES) begin
      case ((i - 1) % 4)
        0:       v = 24'h550000;
        1:       v = 24'h005500;
        2:       v = 24'h000055;
        default: v = 24'h404040;
      endcase
    end else if (i <= 2 * LANES) begin
      v = 24'h550000;
    end else if (i == 2 * LANES + 1) begin
      v = 24'h555555;
    end
    return v;
  endfunction

  function automatic logic [LW-1:0] first_set(
    logic [LANES-1:0] v
  );
    logic [LW-1:0] f;
    f = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (v[i]) f = LW'(i);
    end
    return f;
  endfunction

  function automatic logic [7:0] boost(
    logic [7:0] ch,
    logic [3:0] f
  );
    logic [15:0] s;
    s = {8'h00, ch} + 16'(f) * 16'(FLASH_STEP);
    return (s > 16'd255) ? 8'hFF : s[7:0];
  endfunction

  logic [23:0] pal [N];
  logic [3:0]  flash_cnt [LANES];
  s1_t         s1_d;
  s1_t         s1_q;
  logic [23:0] rd;
  logic [23:0] rgb_d;
  logic        unused_ok;

  assign unused_ok = ^{bus.DrawY, bus.DrawX[2:0]};

  // Reset reloads the palette defaults, not just the pipe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        pal[i] <= pal_init(i);
      end
    end else if (bus.pal_we && bus.pal_addr <= IDX_LAST) begin
      pal[bus.pal_addr] <= bus.pal_data;
    end
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (Reset) begin
        flash_cnt[i] <= 4'd0;
      end else if (bus.hit_pulse[i]) begin
        flash_cnt[i] <= 4'(FLASH_FRAMES);
      end else if (bus.frame_tick && flash_cnt[i] != 4'd0) begin
        flash_cnt[i] <= flash_cnt[i] - 4'd1;
      end
    end
  end

  logic          sel_ball;
  logic          sel_arw;
  logic          sel_rcp;
  logic          sel_rbg;
  logic          sel_bg;
  logic [LW-1:0] arw_lane;
  logic [LW-1:0] rcp_lane;

  assign arw_lane = first_set(bus.display_arrow);
  assign rcp_lane = first_set(bus.is_receptor);

  // Exclusive selects so the decoder can be a unique case.
  assign sel_ball = bus.is_ball;
  assign sel_arw  = !sel_ball && |bus.display_arrow;
  assign sel_rcp  = !sel_ball && !(|bus.display_arrow)
                 && |bus.is_receptor;
  assign sel_rbg  = !sel_ball && !(|bus.display_arrow)
                 && !(|bus.is_receptor)
                 && bus.is_receptor_background;
  assign sel_bg   = !sel_ball && !(|bus.display_arrow)
                 && !(|bus.is_receptor)
                 && !bus.is_receptor_background
                 && bus.is_background;

  always_comb begin
    s1_d       = '0;
    s1_d.valid = bus.pixel_valid;
    s1_d.xq    = bus.DrawX[9:3];
    unique case (1'b1)
      sel_ball: begin
        s1_d.src = SRC_BALL;
        s1_d.idx = IDX_BALL;
      end
      sel_arw: begin
        s1_d.src  = SRC_ARROW;
        s1_d.lane = arw_lane;
        s1_d.idx  = IDX_ARW + AW'(arw_lane);
      end
      sel_rcp: begin
        s1_d.src   = SRC_RCPT;
        s1_d.lane  = rcp_lane;
        s1_d.idx   = IDX_RCP + AW'(rcp_lane);
        s1_d.flash = flash_cnt[rcp_lane];
      end
      sel_rbg: begin
        s1_d.src = SRC_RBG;
        s1_d.idx = IDX_RBG;
      end
      sel_bg: begin
        s1_d.src = SRC_BG;
        s1_d.idx = IDX_BG;
      end
      default: begin
        s1_d.src = SRC_GRAD;
        s1_d.idx = IDX_BG;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  assign rd = pal[s1_q.idx];

  always_comb begin
    rgb_d = rd;
    unique case (s1_q.src)
      SRC_RCPT: begin
        if (s1_q.flash != 4'd0) begin
          rgb_d = {boost(rd[23:16], s1_q.flash),
                   boost(rd[15:8],  s1_q.flash),
                   boost(rd[7:0],   s1_q.flash)};
        end
      end
      SRC_GRAD: begin
        if (GRAD_EN != 0) begin
          rgb_d = {8'h05, 8'h4B,
                   8'h7F - {1'b0, s1_q.xq}};
        end
      end
      default: begin
      end
    endcase
    if (!s1_q.valid) rgb_d = '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.VGA_R     <= 8'h00;
      bus.VGA_G     <= 8'h00;
      bus.VGA_B     <= 8'h00;
      bus.out_valid <= 1'b0;
    end else begin
      bus.VGA_R     <= rgb_d[23:16];
      bus.VGA_G     <= rgb_d[15:8];
      bus.VGA_B     <= rgb_d[7:0];
      bus.out_valid <= s1_q.valid;
    end
  end
endmodule

// File: tb/tb_layer_color_mapper.sv
// Bench for layer_color_mapper: directed scenarios plus a random
// stream scored against a cycle-level colour model.
module tb_layer_color_mapper;
  localparam int L  = 4;
  localparam int NP = 2 * L + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_color_mapper_if #(.LANES(L)) bus();

  layer_color_mapper #(
    .LANES(L),
    .FLASH_FRAMES(8),
    .FLASH_STEP(16),
    .GRAD_EN(1)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [23:0] m_pal [NP];
  int          m_fc [L];
  logic [24:0] m_p1;
  logic [24:0] m_p2;

  typedef struct packed {
    logic        ball;
    logic [3:0]  arw;
    logic [3:0]  rcp;
    logic        rbg;
    logic        bg;
    logic [9:0]  x;
    logic [23:0] rgb;
  } vec_t;

  function automatic logic [23:0] pal_reset_val(int i);
    logic [23:0] a [4];
    a = '{24'h550000, 24'h005500, 24'h000055, 24'h404040};
    if (i == 0) return 24'hFFFFFF;
    if (i <= L) return a[(i - 1) % 4];
    if (i <= 2 * L) return 24'h550000;
    if (i == 2 * L + 1) return 24'h555555;
    return 24'h000000;
  endfunction

  function automatic logic [7:0] sat(int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  function automatic logic [24:0] obs();
    return {bus.out_valid, bus.VGA_R, bus.VGA_G, bus.VGA_B};
  endfunction

  function automatic logic [24:0] ref_pix();
    logic [23:0] c;
    int f;
    if (!bus.pixel_valid) return 25'd0;
    if (bus.is_ball) return {1'b1, m_pal[0]};
    for (int i = 0; i < L; i++)
      if (bus.display_arrow[i]) return {1'b1, m_pal[1 + i]};
    for (int i = 0; i < L; i++) begin
      if (bus.is_receptor[i]) begin
        c = m_pal[1 + L + i];
        f = m_fc[i] * 16;
        return {1'b1, sat(int'(c[23:16]) + f),
                sat(int'(c[15:8]) + f), sat(int'(c[7:0]) + f)};
      end
    end
    if (bus.is_receptor_background) return {1'b1, m_pal[2 * L + 1]};
    if (bus.is_background) return {1'b1, m_pal[2 * L + 2]};
    return {1'b1, 8'h05, 8'h4B, 8'(127 - int'(bus.DrawX) / 8)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_pal[i] = pal_reset_val(i);
    for (int i = 0; i < L; i++) m_fc[i] = 0;
    m_p1 = '0;
    m_p2 = '0;
  endtask

  // Advance the model by one edge using the inputs now applied.
  task automatic tick();
    logic [24:0] px;
    if (rst) begin
      model_reset();
    end else begin
      if (bus.pal_we && int'(bus.pal_addr) < NP)
        m_pal[bus.pal_addr] = bus.pal_data;
      px = ref_pix();
      for (int i = 0; i < L; i++) begin
        if (bus.hit_pulse[i]) m_fc[i] = 8;
        else if (bus.frame_tick && m_fc[i] > 0) m_fc[i]--;
      end
      m_p2 = m_p1;
      m_p1 = px;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.frame_tick             = 1'b0;
    bus.pixel_valid            = 1'b0;
    bus.DrawX                  = '0;
    bus.DrawY                  = '0;
    bus.is_ball                = 1'b0;
    bus.display_arrow          = '0;
    bus.is_receptor            = '0;
    bus.is_receptor_background = 1'b0;
    bus.is_background          = 1'b0;
    bus.hit_pulse              = '0;
    bus.pal_we                 = 1'b0;
    bus.pal_addr               = '0;
    bus.pal_data               = '0;
  endtask

  task automatic drive_entry(int e);
    idle();
    bus.pixel_valid = 1'b1;
    if (e == 0) bus.is_ball = 1'b1;
    else if (e <= L) bus.display_arrow[e - 1] = 1'b1;
    else if (e <= 2 * L) bus.is_receptor[e - 1 - L] = 1'b1;
    else if (e == 2 * L + 1) bus.is_receptor_background = 1'b1;
    else bus.is_background = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.pixel_valid = 1'b1;
    bus.is_ball = 1'b1;
    tick();
    tick();
    total++;
    if (obs() !== 25'd0) begin
      bad++;
      $display("FAIL reset_out got=%h exp=%h", obs(), 25'd0);
    end
    rst = 1'b0;
    bus.display_arrow = 4'b0001;
    tick();
    idle();
    total++;
    if (obs() !== 25'd0) begin
      bad++;
      $display("FAIL reset_latency got=%h exp=%h", obs(), 25'd0);
    end
    tick();
    total++;
    if (obs() !== {1'b1, 24'hFFFFFF}) begin
      bad++;
      $display("FAIL reset_first_ball got=%h exp=%h",
               obs(), {1'b1, 24'hFFFFFF});
    end
  endtask

  task automatic test_priority();
    vec_t tbl [10];
    tbl = '{
      '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 10'd0,  24'hFFFFFF},
      '{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 10'd0,  24'h550000},
      '{1'b0, 4'b1010, 4'b0000, 1'b0, 1'b0, 10'd0,  24'h005500},
      '{1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 10'd0,  24'h550000},
      '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 10'd0,  24'h555555},
      '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 10'd0,  24'h000000},
      '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 10'd80, 24'h054B75},
      '{1'b0, 4'b1000, 4'b1111, 1'b1, 1'b0, 10'd0,  24'h404040},
      '{1'b0, 4'b0000, 4'b1000, 1'b1, 1'b1, 10'd0,  24'h550000},
      '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 10'd1023, 24'h054B00}
    };
    for (int k = 0; k < 10; k++) begin
      idle();
      bus.pixel_valid            = 1'b1;
      bus.is_ball                = tbl[k].ball;
      bus.display_arrow          = tbl[k].arw;
      bus.is_receptor            = tbl[k].rcp;
      bus.is_receptor_background = tbl[k].rbg;
      bus.is_background          = tbl[k].bg;
      bus.DrawX                  = tbl[k].x;
      tick();
      idle();
      tick();
      total++;
      if (obs() !== {1'b1, tbl[k].rgb} || obs() !== m_p2) begin
        bad++;
        $display("FAIL priority[%0d] got=%h exp=%h model=%h",
                 k, obs(), {1'b1, tbl[k].rgb}, m_p2);
      end
    end
  endtask

  task automatic test_flash();
    idle();
    bus.hit_pulse = 4'b0100;
    tick();
    drive_entry(1 + L + 2);
    tick();
    idle();
    tick();
    total++;
    if (obs() !== {1'b1, 24'hD58080}) begin
      bad++;
      $display("FAIL flash_on got=%h exp=%h", obs(), {1'b1, 24'hD58080});
    end
    drive_entry(3);
    tick();
    idle();
    tick();
    total++;
    if (obs() !== {1'b1, 24'h000055}) begin
      bad++;
      $display("FAIL flash_arrow got=%h exp=%h", obs(), {1'b1, 24'h000055});
    end
    drive_entry(1 + L + 2);
    bus.frame_tick = 1'b1;
    tick();
    idle();
    tick();
    total++;
    if (obs() !== {1'b1, 24'hD58080}) begin
      bad++;
      $display("FAIL flash_stage1_cnt got=%h exp=%h",
               obs(), {1'b1, 24'hD58080});
    end
    drive_entry(1 + L + 2);
    tick();
    idle();
    tick();
    total++;
    if (obs() !== {1'b1, 24'hC57070}) begin
      bad++;
      $display("FAIL flash_decay got=%h exp=%h", obs(), {1'b1, 24'hC57070});
    end
    for (int k = 0; k < 7; k++) begin
      bus.frame_tick = 1'b1;
      tick();
      idle();
    end
    drive_entry(1 + L + 2);
    tick();
    idle();
    tick();
    total++;
    if (obs() !== {1'b1, 24'h550000}) begin
      bad++;
      $display("FAIL flash_expired got=%h exp=%h", obs(), {1'b1, 24'h550000});
    end
    bus.hit_pulse  = 4'b0100;
    bus.frame_tick = 1'b1;
    tick();
    drive_entry(1 + L + 2);
    tick();
    idle();
    tick();
    total++;
    if (obs() !== {1'b1, 24'hD58080}) begin
      bad++;
      $display("FAIL flash_load_wins got=%h exp=%h",
               obs(), {1'b1, 24'hD58080});
    end
    for (int k = 0; k < 8; k++) begin
      bus.frame_tick = 1'b1;
      tick();
      idle();
    end
  endtask

  task automatic test_palette();
    drive_entry(2);
    tick();
    drive_entry(2);
    bus.pal_we   = 1'b1;
    bus.pal_addr = 4'd2;
    bus.pal_data = 24'h123456;
    tick();
    idle();
    total++;
    if (obs() !== {1'b1, 24'h005500}) begin
      bad++;
      $display("FAIL pal_old got=%h exp=%h", obs(), {1'b1, 24'h005500});
    end
    tick();
    total++;
    if (obs() !== {1'b1, 24'h123456}) begin
      bad++;
      $display("FAIL pal_new got=%h exp=%h", obs(), {1'b1, 24'h123456});
    end
    bus.pal_we   = 1'b1;
    bus.pal_addr = 4'd15;
    bus.pal_data = 24'hABCDEF;
    tick();
    idle();
    for (int e = 0; e < NP; e++) begin
      drive_entry(e);
      tick();
      idle();
      tick();
      total++;
      if (obs() !== m_p2) begin
        bad++;
        $display("FAIL pal_oob[%0d] got=%h exp=%h", e, obs(), m_p2);
      end
    end
  endtask

  task automatic test_blank();
    idle();
    bus.is_ball     = 1'b1;
    bus.pixel_valid = 1'b1;
    tick();
    bus.pixel_valid = 1'b0;
    tick();
    total++;
    if (obs() !== {1'b1, 24'hFFFFFF}) begin
      bad++;
      $display("FAIL blank_v1 got=%h exp=%h", obs(), {1'b1, 24'hFFFFFF});
    end
    bus.pixel_valid = 1'b1;
    tick();
    total++;
    if (obs() !== 25'd0) begin
      bad++;
      $display("FAIL blank_v0 got=%h exp=%h", obs(), 25'd0);
    end
    idle();
    tick();
    total++;
    if (obs() !== {1'b1, 24'hFFFFFF}) begin
      bad++;
      $display("FAIL blank_v1b got=%h exp=%h", obs(), {1'b1, 24'hFFFFFF});
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 400; k++) begin
      bus.pixel_valid            = ($urandom_range(0, 3) != 0);
      bus.DrawX                  = 10'($urandom_range(0, 1023));
      bus.DrawY                  = 10'($urandom_range(0, 1023));
      bus.is_ball                = ($urandom_range(0, 5) == 0);
      bus.display_arrow          = 4'($urandom) & 4'($urandom);
      bus.is_receptor            = 4'($urandom) & 4'($urandom);
      bus.is_receptor_background = ($urandom_range(0, 2) == 0);
      bus.is_background          = ($urandom_range(0, 1) == 0);
      bus.frame_tick             = ($urandom_range(0, 5) == 0);
      bus.hit_pulse              = 4'($urandom) & 4'($urandom)
                                 & 4'($urandom);
      bus.pal_we                 = ($urandom_range(0, 9) == 0);
      bus.pal_addr               = 4'($urandom_range(0, 15));
      bus.pal_data               = 24'($urandom);
      tick();
      total++;
      if (obs() !== m_p2) begin
        bad++;
        $display("FAIL stream[%0d] got=%h exp=%h", k, obs(), m_p2);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    bus.hit_pulse = 4'b0100;
    bus.pal_we    = 1'b1;
    bus.pal_addr  = 4'd2;
    bus.pal_data  = 24'hABCDEF;
    tick();
    drive_entry(1 + L + 2);
    tick();
    tick();
    total++;
    if (obs() !== {1'b1, 24'hD58080}) begin
      bad++;
      $display("FAIL mid_flash got=%h exp=%h", obs(), {1'b1, 24'hD58080});
    end
    rst = 1'b1;
    tick();
    total++;
    if (obs() !== 25'd0) begin
      bad++;
      $display("FAIL mid_reset got=%h exp=%h", obs(), 25'd0);
    end
    rst = 1'b0;
    tick();
    total++;
    if (obs() !== 25'd0) begin
      bad++;
      $display("FAIL mid_flushed got=%h exp=%h", obs(), 25'd0);
    end
    drive_entry(2);
    tick();
    total++;
    if (obs() !== {1'b1, 24'h550000}) begin
      bad++;
      $display("FAIL mid_rcpt got=%h exp=%h", obs(), {1'b1, 24'h550000});
    end
    idle();
    tick();
    total++;
    if (obs() !== {1'b1, 24'h005500}) begin
      bad++;
      $display("FAIL mid_pal2 got=%h exp=%h", obs(), {1'b1, 24'h005500});
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_priority();
    test_flash();
    test_palette();
    test_blank();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
